f_fetch_ctrl: RTL and testbench

Fetch-stage sequencer for the pipelined MIPS core. It owns the PC register and the next-PC selection (sequential PC+4 or branch/jump redirect). It drives the instruction-memory request/ready handshake and presents a one-entry F/D output buffer that honours decode stalls. Branch delay-slot semantics are preserved: a redirect takes effect on the fetch that follows the instruction currently in F.

---
 rtl/f_fetch_ctrl.sv | 101 ++++++++++
 tb/tb_f_fetch_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/f_fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues instruction-memory requests and
// holds a one-entry F/D buffer that honours decode stalls and delay-slot redirects.
module f_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        D_stall,
    input  logic        D_redirect,
    input  logic [31:0] D_redirect_pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ready,
    input  logic [31:0] im_rdata,
    output logic        F_valid,
    output logic [31:0] F_instr,
    output logic [31:0] F_pc,
    output logic [31:0] F_fetch_cnt
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc, fetch_pc_nxt;
    logic        pend_valid, pend_valid_nxt;
    logic [31:0] pend_pc, pend_pc_nxt;
    logic        f_valid_nxt;
    logic [31:0] f_instr_nxt, f_pc_nxt, fetch_cnt_nxt;
    logic        transfer, consume;

    // Handshake: a word is taken from memory only on a cycle with im_req=1 and
    // im_ready=1; a dropped request leaves fetch_pc untouched so the same address
    // is presented again later.
    assign im_addr = fetch_pc;

    always_comb begin
        state_nxt      = RUN;
        fetch_pc_nxt   = fetch_pc;
        pend_valid_nxt = pend_valid;
        pend_pc_nxt    = pend_pc;
        f_valid_nxt    = F_valid;
        f_instr_nxt    = F_instr;
        f_pc_nxt       = F_pc;
        fetch_cnt_nxt  = F_fetch_cnt;

        im_req   = (state == RUN) && (!F_valid || !D_stall);
        transfer = im_req && im_ready;
        consume  = F_valid && !D_stall;

        if (transfer) begin
            f_valid_nxt   = 1'b1;
            f_instr_nxt   = im_rdata;
            f_pc_nxt      = fetch_pc;
            fetch_cnt_nxt = F_fetch_cnt + 32'd1;
            // A live redirect bypasses any older pending target.
            if (D_redirect) begin
                fetch_pc_nxt = D_redirect_pc;
            end else if (pend_valid) begin
                fetch_pc_nxt   = pend_pc;
                pend_valid_nxt = 1'b0;
            end else begin
                fetch_pc_nxt = fetch_pc + 32'd4;
            end
        end else begin
            if (consume) begin
                f_valid_nxt = 1'b0;
            end
            // Held until the next transfer so the delay slot is fetched first.
            if (D_redirect) begin
                pend_valid_nxt = 1'b1;
                pend_pc_nxt    = D_redirect_pc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_pc     <= 32'd0;
            F_valid     <= 1'b0;
            F_instr     <= 32'd0;
            F_pc        <= 32'd0;
            F_fetch_cnt <= 32'd0;
        end else begin
            state       <= state_nxt;
            fetch_pc    <= fetch_pc_nxt;
            pend_valid  <= pend_valid_nxt;
            pend_pc     <= pend_pc_nxt;
            F_valid     <= f_valid_nxt;
            F_instr     <= f_instr_nxt;
            F_pc        <= f_pc_nxt;
            F_fetch_cnt <= fetch_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_f_fetch_ctrl.sv
// Directed bench for f_fetch_ctrl: a reference model of the fetch rules is
// compared every cycle, plus hand-computed checkpoints along the sequence.
module tb_f_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        D_stall;
    logic        D_redirect;
    logic [31:0] D_redirect_pc;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ready;
    logic [31:0] im_rdata;
    logic        F_valid;
    logic [31:0] F_instr;
    logic [31:0] F_pc;
    logic [31:0] F_fetch_cnt;

    int checks = 0;
    int errors = 0;

    f_fetch_ctrl dut (
        .clk           (clk),
        .reset         (rst),
        .D_stall       (D_stall),
        .D_redirect    (D_redirect),
        .D_redirect_pc (D_redirect_pc),
        .im_req        (im_req),
        .im_addr       (im_addr),
        .im_ready      (im_ready),
        .im_rdata      (im_rdata),
        .F_valid       (F_valid),
        .F_instr       (F_instr),
        .F_pc          (F_pc),
        .F_fetch_cnt   (F_fetch_cnt)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns a word tagged with its own address.
    assign im_rdata = {16'hC0DE, im_addr[15:0]};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cycles since reset, a program counter, one pending target
    // and a one-slot delivery buffer.
    int          m_cycles;
    logic [31:0] m_pc;
    logic        m_has_pend;
    logic [31:0] m_pend;
    logic        m_full;
    logic [31:0] m_word;
    logic [31:0] m_word_pc;
    logic [31:0] m_count;

    function automatic logic model_req();
        return (m_cycles >= 1) && (!m_full || !D_stall);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cycles   = 0;
            m_pc       = 32'h0000_3000;
            m_has_pend = 1'b0;
            m_pend     = 32'd0;
            m_full     = 1'b0;
            m_word     = 32'd0;
            m_word_pc  = 32'd0;
            m_count    = 32'd0;
        end else begin
            if (model_req() && im_ready) begin
                m_word    = im_rdata;
                m_word_pc = m_pc;
                m_full    = 1'b1;
                m_count   = m_count + 1;
                if (D_redirect)      m_pc = D_redirect_pc;
                else if (m_has_pend) begin
                    m_pc       = m_pend;
                    m_has_pend = 1'b0;
                end else             m_pc = m_pc + 4;
            end else begin
                if (!D_stall) m_full = 1'b0;
                if (D_redirect) begin
                    m_has_pend = 1'b1;
                    m_pend     = D_redirect_pc;
                end
            end
            if (m_cycles < 2) m_cycles++;
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        check("m_im_req",  {31'd0, im_req},  {31'd0, model_req()});
        check("m_im_addr", im_addr,          m_pc);
        check("m_F_valid", {31'd0, F_valid}, {31'd0, m_full});
        check("m_F_instr", F_instr,          m_word);
        check("m_F_pc",    F_pc,             m_word_pc);
        check("m_cnt",     F_fetch_cnt,      m_count);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; D_stall = 1'b0; D_redirect = 1'b0; D_redirect_pc = 32'd0; im_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req",   {31'd0, im_req},  32'd0);
        check("rst_addr",  im_addr,          32'h0000_3000);
        check("rst_valid", {31'd0, F_valid}, 32'd0);
        check("rst_cnt",   F_fetch_cnt,      32'd0);

        // Streaming with im_ready high
        cyc(); rst = 1'b0; im_ready = 1'b1;
        @(negedge clk); check("boot_req", {31'd0, im_req}, 32'd0);
        cyc(); @(negedge clk);
        check("s_req0",  {31'd0, im_req}, 32'd1);
        check("s_addr0", im_addr, 32'h0000_3000);
        cyc(); @(negedge clk);
        check("s_addr1", im_addr, 32'h0000_3004);
        check("s_pc1",   F_pc,    32'h0000_3000);
        check("s_ins1",  F_instr, 32'hC0DE_3000);
        cyc(); @(negedge clk);
        check("s_addr2", im_addr, 32'h0000_3008);
        check("s_pc2",   F_pc,    32'h0000_3004);
        cyc(); @(negedge clk);
        check("s_cnt3",  F_fetch_cnt, 32'd3);

        // Delayed im_ready
        cyc(); rst = 1'b1; im_ready = 1'b0;
        cyc(); rst = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("w_req",   {31'd0, im_req},  32'd1);
            check("w_addr",  im_addr,          32'h0000_3000);
            check("w_valid", {31'd0, F_valid}, 32'd0);
            cyc();
        end
        im_ready = 1'b1;
        cyc(); @(negedge clk);
        check("w_valid1", {31'd0, F_valid}, 32'd1);
        check("w_cnt1",   F_fetch_cnt,      32'd1);

        // Stall with full buffer, redirect while stalled (last one wins)
        cyc(); D_stall = 1'b1;
        @(negedge clk);
        check("st_pc",  F_pc, 32'h0000_3004);
        check("st_req", {31'd0, im_req}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i == 1) begin D_redirect = 1'b1; D_redirect_pc = 32'h0000_3050; end
            if (i == 2) D_redirect_pc = 32'h0000_3100;
            if (i == 3) D_redirect = 1'b0;
            @(negedge clk);
            check("st_req_h", {31'd0, im_req}, 32'd0);
            check("st_pc_h",  F_pc, 32'h0000_3004);
            check("st_ins_h", F_instr, 32'hC0DE_3004);
        end
        cyc(); D_stall = 1'b0;
        @(negedge clk);
        check("rel_req",  {31'd0, im_req}, 32'd1);
        check("rel_addr", im_addr, 32'h0000_3008);
        cyc(); @(negedge clk);
        check("ds_pc",   F_pc,    32'h0000_3008);
        check("ds_addr", im_addr, 32'h0000_3100);
        cyc(); @(negedge clk);
        check("rd_addr", im_addr, 32'h0000_3104);

        // Redirect coincident with a transfer takes the bypass
        cyc(); D_redirect = 1'b1; D_redirect_pc = 32'h0000_3200;
        cyc(); D_redirect = 1'b0;
        @(negedge clk);
        check("by_addr", im_addr, 32'h0000_3200);
        cyc(); @(negedge clk);
        check("by_next", im_addr, 32'h0000_3204);

        // Stall release with memory not ready: buffer drains
        cyc(); D_stall = 1'b1;
        cyc(); D_stall = 1'b0; im_ready = 1'b0;
        @(negedge clk);
        check("dr_req", {31'd0, im_req}, 32'd1);
        cyc(); @(negedge clk);
        check("dr_valid", {31'd0, F_valid}, 32'd0);

        // Pending redirect survives idle cycles; PC wraps past the top
        cyc(); D_redirect = 1'b1; D_redirect_pc = 32'hFFFF_FFFC;
        cyc(); D_redirect = 1'b0;
        cyc(); im_ready = 1'b1;
        @(negedge clk);
        check("pd_addr", im_addr, 32'h0000_3208);
        cyc(); @(negedge clk);
        check("pd_tgt", im_addr, 32'hFFFF_FFFC);
        cyc(); @(negedge clk);
        check("wrap_addr", im_addr, 32'h0000_0000);
        cyc(); @(negedge clk);
        check("wrap_next", im_addr, 32'h0000_0004);

        // Asynchronous reset while a request is outstanding
        cyc(); im_ready = 1'b0;
        @(negedge clk);
        check("ar_pre", {31'd0, im_req}, 32'd1);
        cyc(); rst = 1'b1;
        #1;
        check("ar_req",   {31'd0, im_req},  32'd0);
        check("ar_valid", {31'd0, F_valid}, 32'd0);
        check("ar_addr",  im_addr,          32'h0000_3000);
        cyc(); rst = 1'b0;
        cyc(); im_ready = 1'b1;
        @(negedge clk);
        check("ar_restart", im_addr, 32'h0000_3000);
        check("ar_cnt",     F_fetch_cnt, 32'd0);
        repeat (3) cyc();
        @(negedge clk);
        check("ar_cnt3", F_fetch_cnt, 32'd3);

        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
